mandel_pixel_scheduler: RTL and testbench

//  Frame-level sequencer for a pool of NUM_ENGINES Mandelbrot iteration engines. Sweeps the pixel grid
//  in raster order and generates the fixed-point c = (c_re, c_im) for each pixel. Dispatches pixels

---
 rtl/mandel_pkg.sv | 9 +
 rtl/mandel_rr_pick.sv | 27 ++
 rtl/mandel_pixel_scheduler.sv | 163 ++++++++++++++++
 tb/tb_mandel_pixel_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// mandel_pkg: shared fixed-point coordinate type, scheduler FSM states and iteration-count width
package mandel_pkg;
    localparam int COORD_W = 32;
    localparam int FRAC_W = 24;
    localparam int ITER_W = 10;
    localparam logic [COORD_W-1:0] FX_ONE = COORD_W'(1) << FRAC_W;
    typedef logic signed [COORD_W-1:0] coord_t;
    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/mandel_rr_pick.sv
// mandel_rr_pick: grants the first requester at or after ptr, wrapping modulo N
module mandel_rr_pick #(
    parameter int N = 4,
    localparam int W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         valid
);
    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        grant = '0;
        idx = '0;
        valid = |req;
        for (int k = N - 1; k >= 0; k--) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && i == (int'(ptr) + k) % N) begin
                    grant = '0;
                    grant[i] = 1'b1;
                    idx = W'(i);
                end
            end
        end
    end
endmodule

// File: rtl/mandel_pixel_scheduler.sv
// mandel_pixel_scheduler: raster-order pixel dispatch to a pool of Mandelbrot engines,
// with per-engine result slots drained round-robin into (address, iteration) writes.
module mandel_pixel_scheduler #(
    parameter int BIT_WIDTH = mandel_pkg::COORD_W,
    parameter int FRAC_BITS = mandel_pkg::FRAC_W,
    parameter int NUM_ENGINES = 4,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int ITER_W = mandel_pkg::ITER_W,
    localparam int ADDR_W = $clog2(H_RES * V_RES),
    localparam int EID_W = NUM_ENGINES > 1 ? $clog2(NUM_ENGINES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic [BIT_WIDTH-1:0]          x_min,
    input  logic [BIT_WIDTH-1:0]          y_max,
    input  logic [BIT_WIDTH-1:0]          step,
    output logic                          frame_busy,
    output logic                          frame_done,
    output logic [NUM_ENGINES-1:0]        eng_start,
    output logic [BIT_WIDTH-1:0]          eng_c_re,
    output logic [BIT_WIDTH-1:0]          eng_c_im,
    input  logic [NUM_ENGINES-1:0]        eng_idle,
    input  logic [NUM_ENGINES-1:0]        eng_done,
    input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [ADDR_W-1:0]             pix_addr,
    output logic [ITER_W-1:0]             pix_iter
);
    import mandel_pkg::*;

    localparam int NPIX = H_RES * V_RES;
    localparam int COL_W = H_RES > 1 ? $clog2(H_RES) : 1;

    state_t state, state_n;
    logic [BIT_WIDTH-1:0] xmin_q, step_q, c_re, c_im;
    logic [BIT_WIDTH-1:0] cur_re, cur_im, cur_step, base_re;
    logic [COL_W-1:0] col, cur_col;
    logic [ADDR_W-1:0] addr, cur_addr, drain_addr;
    logic [ITER_W-1:0] drain_iter;
    logic [NUM_ENGINES-1:0] inflight, slot_full, cap, disp_req, disp_gnt, drain_req, drain_gnt;
    logic [EID_W-1:0] rr_disp, rr_drain, disp_idx, drain_idx;
    logic disp_vld, drain_vld, launch, drain_fire, last_pix, col_wrap, drained;
    logic [ADDR_W-1:0] tag [NUM_ENGINES];
    logic [ADDR_W-1:0] slot_addr [NUM_ENGINES];
    logic [ITER_W-1:0] slot_iter [NUM_ENGINES];

    function automatic logic [EID_W-1:0] nxt(input logic [EID_W-1:0] i);
        return i == EID_W'(NUM_ENGINES - 1) ? '0 : i + EID_W'(1);
    endfunction

    mandel_rr_pick #(.N(NUM_ENGINES)) u_disp_pick (
        .req(disp_req), .ptr(rr_disp), .grant(disp_gnt), .idx(disp_idx), .valid(disp_vld)
    );

    mandel_rr_pick #(.N(NUM_ENGINES)) u_drain_pick (
        .req(drain_req), .ptr(rr_drain), .grant(drain_gnt), .idx(drain_idx), .valid(drain_vld)
    );

    // The launching cycle dispatches straight from the frame inputs, so the first
    // eng_start follows frame_start by one cycle.
    always_comb begin
        launch = state == S_IDLE && frame_start;
        cur_re = launch ? x_min : c_re;
        cur_im = launch ? y_max : c_im;
        cur_step = launch ? step : step_q;
        base_re = launch ? x_min : xmin_q;
        cur_col = launch ? '0 : col;
        cur_addr = launch ? '0 : addr;
        col_wrap = cur_col == COL_W'(H_RES - 1);
        last_pix = cur_addr == ADDR_W'(NPIX - 1);
        disp_req = (launch || state == S_DISPATCH) ? eng_idle & ~inflight & ~slot_full : '0;
        cap = eng_done & inflight;
        drain_req = slot_full | cap;
        drain_fire = drain_vld && (!pix_valid || pix_ready);
        drained = inflight == '0 && slot_full == '0 && !pix_valid;
        state_n = state == S_DONE ? S_IDLE :
                  state == S_DRAIN ? (drained ? S_DONE : S_DRAIN) :
                  (disp_vld && last_pix) ? S_DRAIN :
                  (launch || state == S_DISPATCH) ? S_DISPATCH : S_IDLE;
    end

    // A just-completing engine bypasses its slot, giving one-cycle result latency.
    always_comb begin
        drain_addr = '0;
        drain_iter = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (drain_gnt[i]) begin
                drain_addr = slot_full[i] ? slot_addr[i] : tag[i];
                drain_iter = slot_full[i] ? slot_iter[i] : eng_iter[i*ITER_W +: ITER_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            eng_start <= '0;
            eng_c_re <= '0;
            eng_c_im <= '0;
            pix_valid <= 1'b0;
            pix_addr <= '0;
            pix_iter <= '0;
            inflight <= '0;
            slot_full <= '0;
            rr_disp <= '0;
            rr_drain <= '0;
            xmin_q <= '0;
            step_q <= '0;
            c_re <= '0;
            c_im <= '0;
            col <= '0;
            addr <= '0;
        end else begin
            state <= state_n;
            frame_busy <= state_n == S_DISPATCH || state_n == S_DRAIN;
            frame_done <= state_n == S_DONE;
            eng_start <= disp_vld ? disp_gnt : '0;
            inflight <= (inflight & ~cap) | (disp_vld ? disp_gnt : '0);
            slot_full <= (slot_full | cap) & ~(drain_fire ? drain_gnt : '0);
            if (launch) begin
                xmin_q <= x_min;
                step_q <= step;
            end
            if (disp_vld) begin
                eng_c_re <= cur_re;
                eng_c_im <= cur_im;
                rr_disp <= nxt(disp_idx);
                addr <= cur_addr + ADDR_W'(1);
                col <= col_wrap ? '0 : cur_col + COL_W'(1);
                c_re <= col_wrap ? base_re : cur_re + cur_step;
                c_im <= col_wrap ? cur_im - cur_step : cur_im;
            end else if (launch) begin
                c_re <= x_min;
                c_im <= y_max;
                col <= '0;
                addr <= '0;
            end
            if (drain_fire) begin
                pix_valid <= 1'b1;
                pix_addr <= drain_addr;
                pix_iter <= drain_iter;
                rr_drain <= nxt(drain_idx);
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (disp_vld && disp_gnt[i]) tag[i] <= cur_addr;
            if (cap[i]) begin
                slot_addr[i] <= tag[i];
                slot_iter[i] <= eng_iter[i*ITER_W +: ITER_W];
            end
        end
    end
endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// tb_mandel_pixel_scheduler: directed and randomized frames against a raster-order
// coordinate model and behavioural engines whose iteration count is a hash of c.
module tb_mandel_pixel_scheduler;
    import mandel_pkg::*;

    localparam int N = 4, H = 4, V = 2, NP = H * V, IW = 10, AW = 3;

    logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0;
    logic [31:0] x_min = '0, y_max = '0, step = '0;
    logic frame_busy, frame_done, pix_valid;
    logic [N-1:0] eng_start;
    logic [N-1:0] eng_idle = '1, eng_done = '0;
    logic [31:0] eng_c_re, eng_c_im;
    logic [N*IW-1:0] eng_iter = '0;
    logic pix_ready = 1'b1;
    logic [AW-1:0] pix_addr;
    logic [IW-1:0] pix_iter;

    always #5 clk = ~clk;

    mandel_pixel_scheduler #(
        .BIT_WIDTH(32), .FRAC_BITS(24), .NUM_ENGINES(N), .H_RES(H), .V_RES(V), .ITER_W(IW)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .x_min(x_min), .y_max(y_max),
        .step(step), .frame_busy(frame_busy), .frame_done(frame_done), .eng_start(eng_start),
        .eng_c_re(eng_c_re), .eng_c_im(eng_c_im), .eng_idle(eng_idle), .eng_done(eng_done),
        .eng_iter(eng_iter), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_addr(pix_addr), .pix_iter(pix_iter)
    );

    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] mx, my, ms;
    int disp_n, deliv_n, done_n, last_start, done_c;
    int lat_lo = 3, lat_hi = 3, ready_pct = 100;
    bit hold = 1'b0, fixed_frame = 1'b0;
    bit busy [N];
    int cnt [N];
    logic [31:0] ere [N], eim [N];
    bit seen [NP];
    int dlv_cyc [NP], dlv_addr [NP];

    function automatic logic [IW-1:0] fval(input logic [31:0] re, input logic [31:0] im);
        logic [31:0] h;
        h = re ^ (re >> 10) ^ (re >> 20) ^ (im * 3) ^ (im >> 12);
        return h[IW-1:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs just before the edge, then advance the engine models.
    task automatic tick();
        logic [N-1:0] st;
        logic [31:0] xr, xi;
        int a;
        if (pix_valid && pix_ready) begin
            a = int'(pix_addr);
            check("addr_dup", 128'(seen[a]), 128'(0));
            check("pix_iter", 128'(pix_iter), 128'(fval(mx + 32'(a % H) * ms, my - 32'(a / H) * ms)));
            seen[a] = 1'b1;
            if (deliv_n < NP) begin
                dlv_cyc[deliv_n] = cyc;
                dlv_addr[deliv_n] = a;
            end
            deliv_n++;
        end
        st = eng_start;
        if (st != '0) begin
            check("start_onehot", 128'($onehot(st)), 128'(1));
            xr = mx + 32'(disp_n % H) * ms;
            xi = my - 32'(disp_n / H) * ms;
            check("c_re", 128'(eng_c_re), 128'(xr));
            check("c_im", 128'(eng_c_im), 128'(xi));
            if (fixed_frame && disp_n == 7) begin
                check("addr7_c_re", 128'(eng_c_re), 128'(32'hFEC0_0000));
                check("addr7_c_im", 128'(eng_c_im), 128'(32'h00C0_0000));
            end
            for (int i = 0; i < N; i++) begin
                if (st[i]) begin
                    check("start_to_busy_engine", 128'(busy[i]), 128'(0));
                    ere[i] = eng_c_re;
                    eim[i] = eng_c_im;
                end
            end
            disp_n++;
            last_start = cyc;
        end
        if (frame_done) done_n++;
        @(posedge clk);
        #1;
        cyc++;
        eng_done = '0;
        for (int i = 0; i < N; i++) begin
            if (busy[i]) begin
                if (cnt[i] > 0) cnt[i]--;
                if (cnt[i] == 0 && !hold) begin
                    eng_done[i] = 1'b1;
                    eng_iter[i*IW +: IW] = fval(ere[i], eim[i]);
                    busy[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (st[i]) begin
                busy[i] = 1'b1;
                cnt[i] = int'($urandom_range(lat_hi, lat_lo));
            end
            eng_idle[i] = !busy[i];
        end
        pix_ready = int'($urandom_range(99, 0)) < ready_pct;
    endtask

    task automatic reset_models();
        for (int i = 0; i < N; i++) begin
            busy[i] = 1'b0;
            cnt[i] = 0;
        end
        eng_done = '0;
        eng_idle = '1;
    endtask

    task automatic check_zero(input string tag);
        check(tag, 128'({frame_busy, frame_done, eng_start, eng_c_re, eng_c_im,
                         pix_valid, pix_addr, pix_iter}), 128'(0));
    endtask

    task automatic start_frame(input logic [31:0] xm, input logic [31:0] ym,
                               input logic [31:0] stp, input bit fixed);
        frame_start = 1'b1;
        x_min = xm;
        y_max = ym;
        step = stp;
        mx = xm;
        my = ym;
        ms = stp;
        fixed_frame = fixed;
        disp_n = 0;
        deliv_n = 0;
        done_n = 0;
        for (int i = 0; i < NP; i++) seen[i] = 1'b0;
        tick();
        frame_start = 1'b0;
        x_min = $urandom;
        y_max = $urandom;
        step = $urandom;
        check("busy_after_start", 128'(frame_busy), 128'(1));
        check("first_start_next_cycle", 128'(eng_start != '0), 128'(1));
    endtask

    task automatic run_frame(input int budget);
        int s;
        for (int k = 0; k < budget && done_n == 0; k++) tick();
        check("frame_done_seen", 128'(done_n), 128'(1));
        repeat (4) tick();
        s = 0;
        for (int i = 0; i < NP; i++) s += int'(seen[i]);
        check("frame_done_once", 128'(done_n), 128'(1));
        check("deliver_count", 128'(deliv_n), 128'(NP));
        check("dispatch_count", 128'(disp_n), 128'(NP));
        check("all_addrs_seen", 128'(s), 128'(NP));
        check("busy_low_after", 128'(frame_busy), 128'(0));
        check("done_low_after", 128'(frame_done), 128'(0));
    endtask

    initial begin
        logic [AW-1:0] held_addr;
        logic [IW-1:0] held_iter;
        reset_models();
        rst = 1'b1;
        tick();
        tick();
        check_zero("reset_outputs");
        rst = 1'b0;
        tick();

        start_frame(32'(0) - (FX_ONE << 1), FX_ONE, FX_ONE >> 2, 1'b1);
        run_frame(500);

        ready_pct = 0;
        start_frame($urandom, $urandom, $urandom, 1'b0);
        repeat (12) tick();
        frame_start = 1'b1;
        x_min = $urandom;
        tick();
        frame_start = 1'b0;
        check("start_while_busy_ignored", 128'(frame_busy), 128'(1));
        repeat (17) tick();
        check("stall_dispatched", 128'(disp_n), 128'(N + 1));
        check("stall_quiet", 128'((cyc - last_start) >= 10), 128'(1));
        check("stall_no_delivery", 128'(deliv_n), 128'(0));
        check("stall_pix_valid", 128'(pix_valid), 128'(1));
        held_addr = pix_addr;
        held_iter = pix_iter;
        tick();
        check("stall_addr_stable", 128'(pix_addr), 128'(held_addr));
        check("stall_iter_stable", 128'(pix_iter), 128'(held_iter));
        ready_pct = 100;
        run_frame(500);

        lat_lo = 1;
        lat_hi = 60;
        ready_pct = 70;
        for (int f = 0; f < 3; f++) begin
            start_frame($urandom, $urandom, $urandom, 1'b0);
            run_frame(3000);
        end

        lat_lo = 3;
        lat_hi = 3;
        ready_pct = 100;
        start_frame($urandom, $urandom, $urandom, 1'b0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check_zero("midframe_reset_outputs");
        reset_models();
        rst = 1'b0;
        tick();

        hold = 1'b1;
        start_frame($urandom, $urandom, $urandom, 1'b0);
        repeat (10) tick();
        check("held_dispatch", 128'(disp_n), 128'(N));
        hold = 1'b0;
        tick();
        done_c = cyc;
        check("all_done_pulse", 128'(eng_done), 128'({N{1'b1}}));
        run_frame(500);
        for (int k = 0; k < N; k++) begin
            check("burst_cycle", 128'(dlv_cyc[k]), 128'(done_c + 1 + k));
            check("burst_rr_addr", 128'(dlv_addr[k]), 128'(k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
